branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_pkg.sv | 38 +++
 rtl/branch_resolve_cond_check.sv | 40 ++++
 rtl/branch_resolve.sv | 96 +++++++++
 tb/tb_branch_resolve.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared processor types: branch classes, LEGv8 condition codes and the
// branch-resolve flush sequencer states.
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_CBZ   = 3'd2,
    BR_CBNZ  = 3'd3,
    BR_BCOND = 3'd4
  } br_type_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH1 = 2'd1,
    ST_FLUSH2 = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_resolve_cond_check.sv
// LEGv8 condition-code evaluator against an NZCV nibble; purely combinational
// so later pipeline stages can reuse it.
module cond_check
  import branch_resolve_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    pass = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_HS: pass = c;
      COND_LO: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: NZCV register, taken decision, target address
// and a two-cycle fetch flush sequence with a one-cycle redirect strobe.
module branch_resolve
  import branch_resolve_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [2:0]  br_type_i,
  input  logic [3:0]  cond_i,
  input  logic        is_zero_i,
  input  logic        alu_n_i,
  input  logic        alu_c_i,
  input  logic        alu_v_i,
  input  logic        set_flags_i,
  input  logic [63:0] pc_i,
  input  logic [25:0] imm26_i,
  input  logic [18:0] imm19_i,
  output logic        redirect_o,
  output logic [63:0] target_o,
  output logic        flush_o,
  output logic [3:0]  flags_o
);

  br_state_e   state;
  logic [3:0]  nzcv;
  logic        cond_pass;
  logic        accept;
  logic        taken;
  logic [63:0] offset;
  logic [63:0] target_next;

  // Conditions see only the registered flags left by older instructions.
  cond_check u_cond_check (
    .cond (cond_i),
    .nzcv (nzcv),
    .pass (cond_pass)
  );

  assign accept = valid_i & ~stall_i & (state == ST_RUN);

  always_comb begin
    taken = 1'b0;
    case (br_type_i)
      BR_B:     taken = 1'b1;
      BR_CBZ:   taken = is_zero_i;
      BR_CBNZ:  taken = ~is_zero_i;
      BR_BCOND: taken = cond_pass;
      default:  taken = 1'b0;
    endcase
  end

  assign offset = (br_type_i == BR_B) ? {{36{imm26_i[25]}}, imm26_i, 2'b00}
                                      : {{43{imm19_i[18]}}, imm19_i, 2'b00};
  assign target_next = pc_i + offset;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      nzcv       <= '0;
      redirect_o <= 1'b0;
      flush_o    <= 1'b0;
      target_o   <= '0;
    end else if (!stall_i) begin
      unique case (state)
        ST_RUN: begin
          if (accept && set_flags_i)
            nzcv <= {alu_n_i, is_zero_i, alu_c_i, alu_v_i};
          if (accept && taken) begin
            state      <= ST_FLUSH1;
            redirect_o <= 1'b1;
            flush_o    <= 1'b1;
            target_o   <= target_next;
          end
        end
        ST_FLUSH1: begin
          state      <= ST_FLUSH2;
          redirect_o <= 1'b0;
        end
        ST_FLUSH2: begin
          state   <= ST_RUN;
          flush_o <= 1'b0;
        end
        default: begin
          state      <= ST_RUN;
          redirect_o <= 1'b0;
          flush_o    <= 1'b0;
        end
      endcase
    end
  end

  assign flags_o = nzcv;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized
// traffic scored against a countdown-based reference model.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, valid_i, stall_i;
  logic [2:0]  br_type_i;
  logic [3:0]  cond_i;
  logic        is_zero_i, alu_n_i, alu_c_i, alu_v_i, set_flags_i;
  logic [63:0] pc_i;
  logic [25:0] imm26_i;
  logic [18:0] imm19_i;
  logic        redirect_o;
  logic [63:0] target_o;
  logic        flush_o;
  logic [3:0]  flags_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles of flush remaining, architectural flags, last target.
  int          m_left;
  logic [3:0]  m_flags;
  logic [63:0] m_target;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .stall_i(stall_i),
    .br_type_i(br_type_i), .cond_i(cond_i), .is_zero_i(is_zero_i),
    .alu_n_i(alu_n_i), .alu_c_i(alu_c_i), .alu_v_i(alu_v_i),
    .set_flags_i(set_flags_i), .pc_i(pc_i), .imm26_i(imm26_i), .imm19_i(imm19_i),
    .redirect_o(redirect_o), .target_o(target_o), .flush_o(flush_o), .flags_o(flags_o)
  );

  // ARM-style: even code is a base test, odd code its inverse; 14/15 always.
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] != 3'd7 && c[0]) base = !base;
    return base;
  endfunction

  function automatic void model_step();
    bit taken;
    longint off;
    if (!reset_n) begin
      m_left = 0; m_flags = 4'h0; m_target = 64'h0;
    end else if (!stall_i) begin
      if (m_left > 0) m_left--;
      else if (valid_i) begin
        case (br_type_i)
          3'd1: taken = 1'b1;
          3'd2: taken = is_zero_i;
          3'd3: taken = !is_zero_i;
          3'd4: taken = cond_true(cond_i, m_flags);
          default: taken = 1'b0;
        endcase
        if (set_flags_i) m_flags = {alu_n_i, is_zero_i, alu_c_i, alu_v_i};
        if (taken) begin
          m_left = 2;
          off = (br_type_i == 3'd1) ? longint'($signed(imm26_i)) * 4
                                    : longint'($signed(imm19_i)) * 4;
          m_target = pc_i + 64'(off);
        end
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0; stall_i = 1'b0; br_type_i = 3'd0; cond_i = 4'd0;
    is_zero_i = 1'b0; alu_n_i = 1'b0; alu_c_i = 1'b0; alu_v_i = 1'b0;
    set_flags_i = 1'b0; pc_i = '0; imm26_i = '0; imm19_i = '0;
  endtask

  task automatic branch(input logic [2:0] t, input logic [3:0] c, input logic z,
                        input logic [63:0] pc, input logic [25:0] i26, input logic [18:0] i19);
    idle();
    valid_i = 1'b1; br_type_i = t; cond_i = c; is_zero_i = z;
    pc_i = pc; imm26_i = i26; imm19_i = i19;
  endtask

  task automatic test_reset();
    idle(); reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_o); end
    n_checks++; if (flags_o !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %h want 0", flags_o); end
    n_checks++; if (target_o !== 64'h0) begin n_fail++; $display("FAIL reset_target: got %h want 0", target_o); end
  endtask

  task automatic test_cbz();
    branch(3'd2, 4'd0, 1'b1, 64'h100, 26'd0, 19'd4);
    tick();
    n_checks++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL cbz_redirect: got %b want 1", redirect_o); end
    n_checks++; if (target_o !== 64'h110) begin n_fail++; $display("FAIL cbz_target: got %h want 110", target_o); end
    n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL cbz_flush1: got %b want 1", flush_o); end
    idle(); tick();
    n_checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b1) begin n_fail++; $display("FAIL cbz_flush2: got redirect=%b flush=%b want 0/1", redirect_o, flush_o); end
    tick();
    n_checks++; if (flush_o !== 1'b0 || target_o !== 64'h110) begin n_fail++; $display("FAIL cbz_done: got flush=%b target=%h want 0/110", flush_o, target_o); end
  endtask

  task automatic test_flags_bcond();
    idle(); valid_i = 1'b1; set_flags_i = 1'b1; is_zero_i = 1'b1; alu_c_i = 1'b1;
    tick();
    n_checks++; if (flags_o !== 4'b0110) begin n_fail++; $display("FAIL subs_flags: got %b want 0110", flags_o); end
    // current ALU outputs say non-zero; only the registered Z may matter
    branch(3'd4, 4'd0, 1'b0, 64'h200, 26'd0, 19'h7FFFF);
    tick();
    n_checks++; if (redirect_o !== 1'b1 || target_o !== 64'h1FC) begin n_fail++; $display("FAIL bcond_eq: got redirect=%b target=%h want 1/1fc", redirect_o, target_o); end
    idle(); tick(); tick();
    branch(3'd4, 4'd1, 1'b0, 64'h200, 26'd0, 19'h7FFFF);
    tick();
    n_checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL bcond_ne: got redirect=%b flush=%b want 0/0", redirect_o, flush_o); end
    n_checks++; if (target_o !== 64'h1FC) begin n_fail++; $display("FAIL target_hold: got %h want 1fc", target_o); end
  endtask

  task automatic test_wrap();
    branch(3'd1, 4'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 26'd2, 19'd0);
    tick();
    n_checks++; if (redirect_o !== 1'b1 || target_o !== 64'h4) begin n_fail++; $display("FAIL wrap: got redirect=%b target=%h want 1/4", redirect_o, target_o); end
    idle(); tick(); tick();
  endtask

  task automatic test_squash();
    branch(3'd1, 4'd0, 1'b0, 64'h1000, 26'd8, 19'd0);
    tick();
    idle(); valid_i = 1'b1; set_flags_i = 1'b1; is_zero_i = 1'b0; alu_n_i = 1'b1;
    tick();
    n_checks++; if (flags_o !== 4'b0110) begin n_fail++; $display("FAIL squash_flags: got %b want 0110", flags_o); end
    branch(3'd2, 4'd0, 1'b1, 64'h3000, 26'd0, 19'd1);
    tick();
    idle(); tick();
    n_checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0 || target_o !== 64'h1020) begin n_fail++; $display("FAIL squash_branch: got redirect=%b flush=%b target=%h want 0/0/1020", redirect_o, flush_o, target_o); end
  endtask

  task automatic test_stall();
    branch(3'd1, 4'd0, 1'b0, 64'h4000, 26'h3FFFFFC, 19'd0);
    tick();
    branch(3'd2, 4'd0, 1'b1, 64'h8000, 26'd0, 19'd9);
    stall_i = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (redirect_o !== 1'b1 || flush_o !== 1'b1 || target_o !== 64'h3FF0) begin n_fail++; $display("FAIL stall_hold%0d: got redirect=%b flush=%b target=%h want 1/1/3ff0", i, redirect_o, flush_o, target_o); end
    end
    idle(); tick();
    n_checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b1) begin n_fail++; $display("FAIL stall_flush2: got redirect=%b flush=%b want 0/1", redirect_o, flush_o); end
    tick();
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL stall_run: got flush=%b want 0", flush_o); end
  endtask

  task automatic test_reset_mid_flush();
    branch(3'd1, 4'd0, 1'b0, 64'h500, 26'd1, 19'd0);
    tick();
    idle(); reset_n = 1'b0; stall_i = 1'b1;
    tick();
    n_checks++; if ({redirect_o, flush_o, flags_o} !== 6'b0 || target_o !== 64'h0) begin n_fail++; $display("FAIL rst_mid_flush: got redirect=%b flush=%b flags=%b target=%h want all 0", redirect_o, flush_o, flags_o, target_o); end
    reset_n = 1'b1;
    branch(3'd2, 4'd0, 1'b1, 64'h600, 26'd0, 19'd2);
    tick();
    n_checks++; if (redirect_o !== 1'b1 || target_o !== 64'h608) begin n_fail++; $display("FAIL rst_then_run: got redirect=%b target=%h want 1/608", redirect_o, target_o); end
    idle(); tick(); tick();
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(0, 199) != 0);
      stall_i     = ($urandom_range(0, 4) == 0);
      valid_i     = ($urandom_range(0, 3) != 0);
      br_type_i   = 3'($urandom_range(0, 4));
      cond_i      = 4'($urandom);
      is_zero_i   = 1'($urandom);
      alu_n_i     = 1'($urandom);
      alu_c_i     = 1'($urandom);
      alu_v_i     = 1'($urandom);
      set_flags_i = 1'($urandom);
      pc_i        = {32'($urandom), 32'($urandom)};
      imm26_i     = 26'($urandom);
      imm19_i     = 19'($urandom);
      tick();
      n_checks++; if (redirect_o !== (m_left == 2)) begin n_fail++; $display("FAIL rnd_redirect[%0d]: got %b want %b", i, redirect_o, (m_left == 2)); end
      n_checks++; if (flush_o !== (m_left != 0)) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush_o, (m_left != 0)); end
      n_checks++; if (flags_o !== m_flags) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, flags_o, m_flags); end
      n_checks++; if (target_o !== m_target) begin n_fail++; $display("FAIL rnd_target[%0d]: got %h want %h", i, target_o, m_target); end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    m_left = 0; m_flags = 4'h0; m_target = 64'h0;
    idle(); reset_n = 1'b0;
    test_reset();
    test_cbz();
    test_flags_bcond();
    test_wrap();
    test_squash();
    test_stall();
    test_reset_mid_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
